// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and one-entry fetch output stage for a combinational instruction memory.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module fetch_sequencer #(
    parameter int PC_W       = 32,
    parameter int RESET_PC   = 0,
    parameter int IMEM_DEPTH = 128
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] pc,
    input  logic [31:0]     instr,
    input  logic            isdone,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic            halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     stall_count
`endif
);
    typedef enum logic {RUN, HALT} state_t;
    state_t          state_q;
    logic [PC_W-1:0] pc_q, out_pc_q;
    logic [31:0]     out_instr_q;
    logic            out_valid_q, halted_q;
    logic            slot_free, oob, done, fire;
    always_comb begin
        slot_free = !out_valid_q || out_ready;
        oob       = pc_q >= PC_W'(IMEM_DEPTH);
        done      = oob;
        // an unknown isdone must read as not done, so only a true 1 sets it
        if (isdone) done = 1'b1;
        fire      = !redirect_valid && state_q == RUN && slot_free && !done;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pc_q        <= PC_W'(RESET_PC);
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            halted_q    <= 1'b0;
        end else if (redirect_valid) begin
            pc_q        <= redirect_pc;
            out_valid_q <= 1'b0;
            state_q     <= RUN;
            halted_q    <= 1'b0;
        end else if (state_q == RUN && slot_free && done) begin
            state_q     <= HALT;
            halted_q    <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (fire) begin
            out_instr_q <= instr;
            out_pc_q    <= pc_q;
            out_valid_q <= 1'b1;
            pc_q        <= pc_q + 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, stall_count_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (fire && fetch_count_q != '1) fetch_count_q <= fetch_count_q + 1'b1;
            if (state_q == RUN && out_valid_q && !out_ready && stall_count_q != '1)
                stall_count_q <= stall_count_q + 1'b1;
        end
    end
    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif
    assign pc        = pc_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign halted    = halted_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed checks of streaming, stalls, redirects, halting and async reset.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        isdone;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count, stall_count;
`endif
    logic [31:0] mem [0:255];
    logic        dn  [0:255];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign instr  = (pc < 32'd256) ? mem[pc[7:0]] : 32'h0;
    assign isdone = (pc < 32'd256) ? dn[pc[7:0]] : 1'b0;

    fetch_sequencer dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr), .isdone(isdone),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .halted(halted)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h1000_0000 + i;
            dn[i]  = 1'b0;
        end
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        mem[2] = 32'h0020_0113;
        mem[3] = 32'h0030_0193;
        dn[4]  = 1'b1;
        rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        step; step;
        check("rst_valid", out_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", pc, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_instr", out_instr, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step;
            check("stream_valid", out_valid, 1);
            check("stream_pc", out_pc, i);
            check("stream_instr", out_instr, mem[i]);
            check("stream_next_pc", pc, i + 1);
        end
        step;
        check("halt_flag", halted, 1);
        check("halt_valid", out_valid, 0);
        check("halt_pc", pc, 4);
        step;
        check("halt_hold", halted, 1);
        check("halt_hold_pc", pc, 4);
        redirect_valid = 1'b1; redirect_pc = 32'd1;
        step;
        redirect_valid = 1'b0;
        check("rdh_halted", halted, 0);
        check("rdh_pc", pc, 1);
        check("rdh_valid", out_valid, 0);
        step;
        check("rdh_out_pc", out_pc, 1);
        check("rdh_out_valid", out_valid, 1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            check("bp_valid", out_valid, 1);
            check("bp_instr", out_instr, 32'h0010_0093);
            check("bp_out_pc", out_pc, 1);
            check("bp_pc", pc, 2);
        end
        out_ready = 1'b1;
        step;
        check("bp_rel_out_pc", out_pc, 2);
        check("bp_rel_instr", out_instr, 32'h0020_0113);
        check("bp_rel_pc", pc, 3);
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        step;
        redirect_valid = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_pc", pc, 32'h10);
        step;
        check("flush_out_pc", out_pc, 32'h10);
        check("flush_instr", out_instr, 32'h1000_0010);
        check("flush_out_valid", out_valid, 1);
        dn[4] = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'd127;
        step;
        redirect_valid = 1'b0;
        check("oob_pc127", pc, 127);
        step;
        check("oob_out_pc", out_pc, 127);
        check("oob_out_valid", out_valid, 1);
        check("oob_pc128", pc, 128);
        step;
        check("oob_halted", halted, 1);
        check("oob_pc_hold", pc, 128);
        check("oob_drained", out_valid, 0);
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        step;
        redirect_valid = 1'b0;
        step;
        check("ar_pre_valid", out_valid, 1);
        check("ar_pre_pc", pc, 1);
`ifdef FETCH_PERF_EN
        check("perf_fetch", fetch_count, 9);
        check("perf_stall", stall_count, 3);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_halted", halted, 0);
        check("ar_pc", pc, 0);
`ifdef FETCH_PERF_EN
        check("ar_fetch_count", fetch_count, 0);
        check("ar_stall_count", stall_count, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Requester side of the instruction-memory fetch interface. Owns the program counter and drives the word-indexed `pc` into the combinational instruction memory. Samples the returned `instr` and `isdone` in the same cycle. Registers fetched instructions into a one-entry valid/ready output stage feeding decode. Handles stalls from decode, redirects from branches and jumps, and halts when the memory reports end of program.

Parameters:
PC_W, 32, width of `pc`, `redirect_pc` and `out_pc`.
RESET_PC, 0, word index loaded into the PC at reset.
IMEM_DEPTH, 128, number of words in instruction memory; a PC at or above this value is out of range.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
pc  out  PC_W  word index presented to instruction memory; equals internal pc_q.
instr  in  32  instruction word for `pc`, valid in the same cycle (combinational memory).
isdone  in  1  end-of-program flag for `pc`, same cycle as `instr`.
redirect_valid  in  1  branch/jump taken this cycle.
redirect_pc  in  PC_W  target word index when redirect_valid=1.
out_valid  out  1  out_instr/out_pc hold a fetched instruction.
out_ready  in  1  decode accepts the output this cycle.
out_instr  out  32  registered instruction.
out_pc  out  PC_W  word index `out_instr` was fetched from.
halted  out  1  sequencer is in HALT; no further fetches.

Behaviour:
- Reset (rst_n=0, asynchronous): pc_q=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0, state=RUN. Deassertion is sampled synchronously; the first fetch happens on the first rising edge with rst_n=1.
- States:
  - RUN: fetching.
  - HALT: `halted`=1, pc_q frozen, no loads into the output stage.
- slot_free = !out_valid || out_ready.
- oob = (pc_q >= IMEM_DEPTH).
- done = (isdone==1) || oob. Any non-1 value on isdone, including X, counts as not done; oob covers reads past the loaded image.
- Priority each edge, highest first:
  1. redirect_valid=1: pc_q<=redirect_pc, out_valid<=0 (the pending instruction is flushed even if out_ready=1), state<=RUN, halted<=0. Nothing is fetched this cycle. Redirect works from RUN and from HALT.
  2. state=RUN, slot_free, done: state<=HALT, halted<=1, pc_q unchanged. If out_valid&&out_ready, out_valid<=0; the already-registered instruction still drains normally.
  3. state=RUN, slot_free, !done (fire): out_instr<=instr, out_pc<=pc_q, out_valid<=1, pc_q<=pc_q+1 (wraps modulo 2^PC_W).
  4. Otherwise: if out_valid&&out_ready then out_valid<=0. out_instr/out_pc hold their value; pc_q holds.
- Latency: an instruction at pc_q in cycle t appears on out_* with out_valid=1 in cycle t+1.
- Throughput: one instruction per cycle while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, out_instr, out_pc, pc_q and `pc` are all stable.
- Simultaneous out_ready=1 and fire: the old entry is consumed and the new one is loaded; out_valid stays 1.
- In HALT, out_valid may remain 1 until consumed. halted and out_valid are independent.
- `pc` output is combinationally equal to pc_q; no other combinational paths from inputs to outputs.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs fetch_count (32) and stall_count (32), both reset to 0.
  - fetch_count increments on every fire.
  - stall_count increments every cycle with state=RUN, out_valid=1, out_ready=0.
  - Both saturate at 0xFFFFFFFF and are not cleared by redirect.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset and stream: memory words 0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00300193; word 4 has isdone=1; out_ready=1. Required: out_pc=0,1,2,3 on consecutive cycles starting one cycle after reset release, each with the matching word. halted=1 from the cycle after pc=4 is presented; pc stays 4.
- Backpressure: hold out_ready=0 for 3 cycles while out_valid=1, out_pc=1. Required: out_instr=0x00100093 and pc=2 stable for all 3 cycles. Releasing out_ready gives out_pc=2 the next cycle, with no duplicate and no lost instruction.
- Redirect flush: out_valid=1, out_pc=2, out_ready=1, redirect_valid=1 with redirect_pc=0x10. Required: next cycle out_valid=0 and pc=0x10; the following cycle out_pc=0x10.
- Redirect from HALT: halted=1 at pc=4, redirect_pc=1. Required: halted=0 next cycle and pc=1; the cycle after, out_pc=1.
- Out of range: IMEM_DEPTH=128, isdone=0 everywhere, redirect_pc=127. Required: out_pc=127 is delivered, then halted=1 with pc=128.
- Async reset mid-stream: assert rst_n=0 between clock edges while out_valid=1. Required: out_valid=0, halted=0 and pc=RESET_PC immediately, without waiting for clk. With FETCH_PERF_EN defined, fetch_count=0 and stall_count=0.
